// File: rtl/dm_ctrl_pkg.sv
// Shared types and default sizes for the data-memory port arbiter.
package dm_ctrl_pkg;

    localparam int DM_ADDR_W      = 14;
    localparam int DM_DATA_W      = 32;
    localparam int DM_DEPTH_WORDS = 4096;
    localparam int DM_LEN_W       = 3;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_BURST
    } state_e;

endpackage

// File: rtl/dm_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the
// requester that was not granted last (last = index of previous winner).
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req[0] && req[1]) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Data-memory port owner: zero-sweeps DM after reset, then serves 1..8 beat
// bursts from two requesters in round-robin order with no preemption.
module dm_port_arbiter
    import dm_ctrl_pkg::*;
#(
    parameter int ADDR_W      = DM_ADDR_W,
    parameter int DATA_W      = DM_DATA_W,
    parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
    parameter int LEN_W       = DM_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [LEN_W-1:0]  m0_len,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [LEN_W-1:0]  m1_len,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              init_done
);

    localparam int WA_W = ADDR_W - 2;

    state_e            state_q, state_d;
    logic [WA_W-1:0]   cnt_q, cnt_d;
    logic [WA_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic              last_q, last_d;
    logic [1:0]        pick;
    logic              unused_addr_lsbs;

    // Byte-lane bits of the requester addresses are never used.
    assign unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

    rr_arb2 u_rr_arb2 (
        .req   ({m1_req, m0_req}),
        .last  (last_q),
        .grant (pick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            base_q  <= '0;
            beat_q  <= '0;
            len_q   <= '0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        beat_d    = beat_q;
        len_d     = len_q;
        owner_d   = owner_q;
        we_d      = we_q;
        last_d    = last_q;
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;

        case (state_q)
            S_INIT: begin
                dm_we   = 1'b1;
                dm_addr = {cnt_q, 2'b00};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == WA_W'(DEPTH_WORDS - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (|pick) begin
                    owner_d = pick[1];
                    we_d    = pick[1] ? m1_we : m0_we;
                    base_d  = pick[1] ? m1_addr[ADDR_W-1:2] : m0_addr[ADDR_W-1:2];
                    len_d   = pick[1] ? m1_len : m0_len;
                    beat_d  = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                m0_gnt  = ~owner_q;
                m1_gnt  = owner_q;
                // Word address wraps naturally at the top of the WA_W-bit space.
                dm_addr = {base_q + WA_W'(beat_q), 2'b00};
                if (we_q) begin
                    dm_we    = 1'b1;
                    dm_wdata = owner_q ? m1_wdata : m0_wdata;
                end else begin
                    m0_rvalid = ~owner_q;
                    m1_rvalid = owner_q;
                end
                beat_d = beat_q + 1'b1;
                if (beat_q == len_q) begin
                    beat_d  = '0;
                    last_d  = owner_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        // Outputs drop in the same cycle reset is asserted, not at the next edge.
        if (!reset) begin
            m0_gnt    = 1'b0;
            m1_gnt    = 1'b0;
            m0_rvalid = 1'b0;
            m1_rvalid = 1'b0;
            dm_we     = 1'b0;
            dm_addr   = '0;
            dm_wdata  = '0;
        end
    end

    assign init_done = reset && (state_q != S_INIT);
    assign m0_rdata  = dm_rdata;
    assign m1_rdata  = dm_rdata;

endmodule
